sprite_draw_ctrl: RTL and testbench

Consumer end of the sprite-movement interface: accepts `move` pulses and coordinates from the player and enemy controllers, and streams per-pixel writes to the VGA adapter. For each accepted request it erases the sprite's previously drawn square in the background colour, then draws the new square in the sprite colour. It sits between the game-logic controllers and the VGA adapter's x/y/colour/plot port.

---
 rtl/project_pkg.sv | 23 ++
 rtl/square_scanner.sv | 42 ++++
 rtl/sprite_draw_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_sprite_draw_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/project_pkg.sv
// Shared constants, colours and draw FSM states for the sprite drawing path.
// The CLEAR state exists only when DRAW_CLEAR_EN is defined.
package project_pkg;

    localparam int SCREEN_W     = 160;
    localparam int SCREEN_H     = 120;
    localparam int PLAYER_WIDTH = 3;

    localparam logic [2:0] PLAYER_COLOUR = 3'b010;
    localparam logic [2:0] ENEMY_COLOUR  = 3'b100;
    localparam logic [2:0] BG_COLOUR     = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ERASE = 2'd1,
        ST_DRAW  = 2'd2
`ifdef DRAW_CLEAR_EN
        ,
        ST_CLEAR = 2'd3
`endif
    } draw_state_t;

endpackage

// File: rtl/square_scanner.sv
// Row-major w x h offset generator: dx inner, dy outer, one offset per cycle.
// A start pulse restarts the scan at (0,0) even if a scan is in progress.
module square_scanner (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] w,
    input  logic [6:0] h,
    output logic [7:0] dx,
    output logic [6:0] dy,
    output logic       last
);

    logic active;
    logic x_end;
    logic y_end;

    assign x_end = (dx == w - 8'd1);
    assign y_end = (dy == h - 7'd1);
    assign last  = active && x_end && y_end;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dx     <= '0;
            dy     <= '0;
            active <= 1'b0;
        end else if (start) begin
            dx     <= '0;
            dy     <= '0;
            active <= 1'b1;
        end else if (active) begin
            if (x_end) begin
                dx <= '0;
                if (y_end) active <= 1'b0;
                else       dy     <= dy + 7'd1;
            end else begin
                dx <= dx + 8'd1;
            end
        end
    end

endmodule

// File: rtl/sprite_draw_ctrl.sv
// Erases and redraws player/enemy squares as a one-pixel-per-cycle VGA write stream.
// Defining DRAW_CLEAR_EN adds the clear port and a full-screen CLEAR scan.
//
// state    | meaning
// ST_IDLE  | no scan; arbitrate clear > player > enemy
// ST_ERASE | repaint the sprite's previous square in background colour
// ST_DRAW  | paint the new square in the sprite colour
// ST_CLEAR | paint every screen pixel in background colour
module sprite_draw_ctrl
    import project_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       player_move,
    input  logic [7:0] playerX,
    input  logic [6:0] playerY,
    input  logic       enemy_move,
    input  logic [7:0] enemyX,
    input  logic [6:0] enemyY,
    input  logic [2:0] enemy_width,
`ifdef DRAW_CLEAR_EN
    input  logic       clear,
`endif
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot,
    output logic       busy
);

    draw_state_t state;

    logic       pl_pend, en_pend, clr_hit;
    logic [7:0] pl_x, en_x;
    logic [6:0] pl_y, en_y;
    logic [2:0] en_w;

    logic       sel;
    logic [7:0] cur_x, base_x, scan_w;
    logic [6:0] cur_y, base_y, scan_h;
    logic [2:0] cur_w;
    logic [1:0] prev_valid;
    logic [7:0] prev_x [2];
    logic [6:0] prev_y [2];
    logic [2:0] prev_w [2];

    logic       take_req, req_sel, scan_start, last;
    logic [7:0] req_x, dx;
    logic [6:0] req_y, dy;
    logic [2:0] req_w, pix_colour;
    logic [8:0] pix_x;
    logic [7:0] pix_y;
    logic       in_screen;

`ifdef DRAW_CLEAR_EN
    logic clr_pend;
    assign clr_hit = clr_pend;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                           clr_pend <= 1'b0;
        else if (clear)                        clr_pend <= 1'b1;
        else if (state == ST_IDLE && clr_pend) clr_pend <= 1'b0;
    end
`else
    assign clr_hit = 1'b0;
`endif

    assign take_req = (state == ST_IDLE) && !clr_hit && (pl_pend || en_pend);
    assign req_sel  = !pl_pend;
    assign req_x    = pl_pend ? pl_x : en_x;
    assign req_y    = pl_pend ? pl_y : en_y;
    assign req_w    = pl_pend ? 3'(PLAYER_WIDTH) : en_w;

    // A new pulse in the same cycle as the take re-arms the latch with fresh coordinates.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pl_pend <= 1'b0;
            en_pend <= 1'b0;
            pl_x    <= '0;
            pl_y    <= '0;
            en_x    <= '0;
            en_y    <= '0;
            en_w    <= '0;
        end else begin
            if (player_move) begin
                pl_pend <= 1'b1;
                pl_x    <= playerX;
                pl_y    <= playerY;
            end else if (take_req && !req_sel) begin
                pl_pend <= 1'b0;
            end
            if (enemy_move) begin
                en_pend <= 1'b1;
                en_x    <= enemyX;
                en_y    <= enemyY;
                en_w    <= enemy_width;
            end else if (take_req && req_sel) begin
                en_pend <= 1'b0;
            end
        end
    end

    assign scan_start = take_req || (state == ST_ERASE && last) || ((state == ST_IDLE) && clr_hit);

    square_scanner u_scan (
        .clk    (clk),
        .resetn (resetn),
        .start  (scan_start),
        .w      (scan_w),
        .h      (scan_h),
        .dx     (dx),
        .dy     (dy),
        .last   (last)
    );

    assign pix_x     = {1'b0, base_x} + {1'b0, dx};
    assign pix_y     = {1'b0, base_y} + {1'b0, dy};
    assign in_screen = (pix_x < 9'(SCREEN_W)) && (pix_y < 8'(SCREEN_H));

    always_comb begin
        pix_colour = BG_COLOUR;
        if (state == ST_DRAW) pix_colour = sel ? ENEMY_COLOUR : PLAYER_COLOUR;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= ST_IDLE;
            sel        <= 1'b0;
            cur_x      <= '0;
            cur_y      <= '0;
            cur_w      <= '0;
            base_x     <= '0;
            base_y     <= '0;
            scan_w     <= '0;
            scan_h     <= '0;
            prev_valid <= '0;
            prev_x     <= '{default: '0};
            prev_y     <= '{default: '0};
            prev_w     <= '{default: '0};
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            vga_plot   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // Outputs trail the scan counters by one register stage.
            vga_plot <= (state != ST_IDLE) && in_screen;
            busy     <= (state != ST_IDLE);
            if (state != ST_IDLE) begin
                vga_x      <= pix_x[7:0];
                vga_y      <= pix_y[6:0];
                vga_colour <= pix_colour;
            end
            case (state)
                ST_IDLE: begin
`ifdef DRAW_CLEAR_EN
                    if (clr_hit) begin
                        state  <= ST_CLEAR;
                        base_x <= '0;
                        base_y <= '0;
                        scan_w <= 8'(SCREEN_W);
                        scan_h <= 7'(SCREEN_H);
                    end else
`endif
                    if (take_req) begin
                        sel   <= req_sel;
                        cur_x <= req_x;
                        cur_y <= req_y;
                        cur_w <= req_w;
                        if (prev_valid[req_sel]) begin
                            state  <= ST_ERASE;
                            base_x <= prev_x[req_sel];
                            base_y <= prev_y[req_sel];
                            scan_w <= {5'b0, prev_w[req_sel]};
                            scan_h <= {4'b0, prev_w[req_sel]};
                        end else begin
                            state  <= ST_DRAW;
                            base_x <= req_x;
                            base_y <= req_y;
                            scan_w <= {5'b0, req_w};
                            scan_h <= {4'b0, req_w};
                        end
                    end
                end
                ST_ERASE: begin
                    if (last) begin
                        state  <= ST_DRAW;
                        base_x <= cur_x;
                        base_y <= cur_y;
                        scan_w <= {5'b0, cur_w};
                        scan_h <= {4'b0, cur_w};
                    end
                end
                ST_DRAW: begin
                    if (last) begin
                        state           <= ST_IDLE;
                        prev_x[sel]     <= cur_x;
                        prev_y[sel]     <= cur_y;
                        prev_w[sel]     <= cur_w;
                        prev_valid[sel] <= 1'b1;
                    end
                end
`ifdef DRAW_CLEAR_EN
                ST_CLEAR: begin
                    if (last) begin
                        state      <= ST_IDLE;
                        prev_valid <= '0;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_draw_ctrl.sv
// Self-checking bench for sprite_draw_ctrl: a pixel model fills a scoreboard queue
// that a negedge monitor drains; covers the clear path when DRAW_CLEAR_EN is defined.
module tb_sprite_draw_ctrl;
    import project_pkg::*;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       player_move = 1'b0;
    logic [7:0] playerX = '0;
    logic [6:0] playerY = '0;
    logic       enemy_move = 1'b0;
    logic [7:0] enemyX = '0;
    logic [6:0] enemyY = '0;
    logic [2:0] enemy_width = 3'd1;
`ifdef DRAW_CLEAR_EN
    logic       clear = 1'b0;
`endif
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;

    always #5 clk = ~clk;

    sprite_draw_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .player_move (player_move),
        .playerX     (playerX),
        .playerY     (playerY),
        .enemy_move  (enemy_move),
        .enemyX      (enemyX),
        .enemyY      (enemyY),
        .enemy_width (enemy_width),
`ifdef DRAW_CLEAR_EN
        .clear       (clear),
`endif
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .busy        (busy)
    );

    typedef struct {
        bit is_enemy;
        int x;
        int y;
        int w;
        int exp_busy;
        int exp_plots;
    } vec_t;

    vec_t        vecs [7];
    int          total = 0;
    int          bad = 0;
    int          busy_cnt = 0;
    int          plot_cnt = 0;
    logic [17:0] exp_q [$];
    logic [17:0] mon_e;
    bit          mv_valid [2];
    int          mv_x [2];
    int          mv_y [2];
    int          mv_w [2];

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (busy) busy_cnt++;
            if (vga_plot) begin
                plot_cnt++;
                if (exp_q.size() == 0) begin
                    check("extra_plot", int'(vga_plot), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pixel", int'({vga_x, vga_y, vga_colour}), int'(mon_e));
                end
            end
        end
    end

    task automatic push_sq(input int bx, input int by, input int w, input logic [2:0] c);
        int xx, yy;
        logic [7:0] px;
        logic [6:0] py;
        for (int dy = 0; dy < w; dy++) begin
            for (int dx = 0; dx < w; dx++) begin
                xx = bx + dx;
                yy = by + dy;
                if (xx < 160 && yy < 120) begin
                    px = xx[7:0];
                    py = yy[6:0];
                    exp_q.push_back({px, py, c});
                end
            end
        end
    endtask

    task automatic model_req(input int s, input int x, input int y, input int w);
        if (mv_valid[s]) push_sq(mv_x[s], mv_y[s], mv_w[s], BG_COLOUR);
        push_sq(x, y, w, (s == 1) ? ENEMY_COLOUR : PLAYER_COLOUR);
        mv_valid[s] = 1'b1;
        mv_x[s] = x;
        mv_y[s] = y;
        mv_w[s] = w;
    endtask

    task automatic req_player(input int x, input int y);
        @(negedge clk);
        player_move = 1'b1;
        playerX = x[7:0];
        playerY = y[6:0];
        @(negedge clk);
        player_move = 1'b0;
    endtask

    task automatic req_enemy(input int x, input int y, input int w);
        @(negedge clk);
        enemy_move = 1'b1;
        enemyX = x[7:0];
        enemyY = y[6:0];
        enemy_width = w[2:0];
        @(negedge clk);
        enemy_move = 1'b0;
    endtask

    // Done once busy has stayed low for three samples; bridges the one-cycle IDLE gap.
    task automatic wait_done(input int budget, input string name);
        int n = 0;
        int idle_run = 0;
        while (idle_run < 3 && n < budget) begin
            @(negedge clk);
            n++;
            if (busy) idle_run = 0;
            else      idle_run++;
        end
        check({name, "_timeout"}, int'(n < budget), 1);
        check({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0,  80, 115, 3,  9,  9};
        vecs[1] = '{0,  79, 115, 3, 18, 18};
        vecs[2] = '{1, 157,   0, 4, 16, 12};
        vecs[3] = '{1,  10,  20, 2, 20, 16};
        vecs[4] = '{0, 158, 118, 3, 18, 13};
        vecs[5] = '{1,   0,   0, 7, 53, 53};
        vecs[6] = '{1, 100,  60, 1, 50, 50};
        mv_valid = '{0, 0};

        repeat (3) @(negedge clk);
        check("rst_vga_x", int'(vga_x), 0);
        check("rst_vga_y", int'(vga_y), 0);
        check("rst_colour", int'(vga_colour), 0);
        check("rst_plot", int'(vga_plot), 0);
        check("rst_busy", int'(busy), 0);
        resetn = 1'b1;

        for (int i = 0; i < 7; i++) begin
            busy_cnt = 0;
            plot_cnt = 0;
            model_req(int'(vecs[i].is_enemy), vecs[i].x, vecs[i].y, vecs[i].w);
            if (vecs[i].is_enemy) req_enemy(vecs[i].x, vecs[i].y, vecs[i].w);
            else                  req_player(vecs[i].x, vecs[i].y);
            wait_done(2000, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_busy", i), busy_cnt, vecs[i].exp_busy);
            check($sformatf("vec%0d_plots", i), plot_cnt, vecs[i].exp_plots);
        end

        // Same-cycle requests: player fully serviced before the enemy.
        busy_cnt = 0;
        model_req(0, 40, 40, 3);
        model_req(1, 60, 50, 3);
        @(negedge clk);
        player_move = 1'b1; playerX = 8'd40; playerY = 7'd40;
        enemy_move = 1'b1;  enemyX = 8'd60;  enemyY = 7'd50; enemy_width = 3'd3;
        @(negedge clk);
        player_move = 1'b0;
        enemy_move = 1'b0;
        wait_done(2000, "simul");
        check("simul_busy", busy_cnt, 28);

        // Three enemy pulses during a player update collapse to the last one.
        busy_cnt = 0;
        model_req(0, 20, 20, 3);
        model_req(1, 120, 100, 5);
        req_player(20, 20);
        enemy_move = 1'b1; enemyX = 8'd130; enemyY = 7'd90;  enemy_width = 3'd2;
        @(negedge clk);
        enemyX = 8'd125; enemyY = 7'd95; enemy_width = 3'd6;
        @(negedge clk);
        enemyX = 8'd120; enemyY = 7'd100; enemy_width = 3'd5;
        @(negedge clk);
        enemy_move = 1'b0;
        wait_done(2000, "latest");
        check("latest_busy", busy_cnt, 52);

`ifdef DRAW_CLEAR_EN
        busy_cnt = 0;
        plot_cnt = 0;
        for (int y = 0; y < 120; y++) push_sq(0, y, 1, BG_COLOUR);
        exp_q.delete();
        push_sq(0, 0, 160, BG_COLOUR);
        mv_valid = '{0, 0};
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        wait_done(20000, "clear");
        check("clear_busy", busy_cnt, 19200);
        check("clear_plots", plot_cnt, 19200);
        busy_cnt = 0;
        model_req(0, 5, 5, 3);
        req_player(5, 5);
        wait_done(2000, "post_clear");
        check("post_clear_busy", busy_cnt, 9);
`endif

        // Reset during DRAW: plot drops asynchronously and the next request skips erase.
        model_req(0, 30, 30, 3);
        req_player(30, 30);
        repeat (14) @(negedge clk);
        check("plot_before_reset", int'(vga_plot), 1);
        #2;
        resetn = 1'b0;
        #1;
        check("async_plot", int'(vga_plot), 0);
        check("async_busy", int'(busy), 0);
        exp_q.delete();
        mv_valid = '{0, 0};
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        busy_cnt = 0;
        plot_cnt = 0;
        model_req(0, 50, 50, 3);
        req_player(50, 50);
        wait_done(2000, "post_rst_pl");
        check("post_rst_pl_busy", busy_cnt, 9);
        check("post_rst_pl_plots", plot_cnt, 9);
        busy_cnt = 0;
        model_req(1, 70, 70, 2);
        req_enemy(70, 70, 2);
        wait_done(2000, "post_rst_en");
        check("post_rst_en_busy", busy_cnt, 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
